// File: rtl/idct_block_fetcher.sv
// Fetches one BLOCK_DIM x BLOCK_DIM block of 16-bit samples from SRAM and
// packs sample pairs into 32-bit DPRAM words, row- or column-major.
module idct_block_fetcher #(
  parameter int BLOCK_DIM    = 8,
  parameter int SRAM_LATENCY = 2,
  parameter int ADDR_W       = 18,
  parameter int RAM_ADDR_W   = 7
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic                  Transpose,
  input  logic [ADDR_W-1:0]     Base_address,
  input  logic [9:0]            Row_stride,
  input  logic [5:0]            Block_row,
  input  logic [5:0]            Block_col,
  input  logic [15:0]           SRAM_read_data,
  output logic [ADDR_W-1:0]     SRAM_address,
  output logic                  SRAM_we_n,
  output logic [15:0]           SRAM_write_data,
  output logic [RAM_ADDR_W-1:0] RAM_address,
  output logic [31:0]           RAM_write_data,
  output logic                  RAM_we,
  output logic                  Busy,
  output logic                  Finish
);

  localparam int DW = $clog2(BLOCK_DIM);
  localparam int L  = SRAM_LATENCY;
  localparam int TW = 2 * DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [9:0]        stride_q, stride_d;
  logic              tr_q, tr_d;
  logic [DW-1:0]     in_q, in_d;
  logic [DW-1:0]     out_q, out_d;
  logic [2:0]        drain_q, drain_d;

  logic [L-1:0]          vld_q, vld_d;
  logic [L-1:0][TW-1:0]  tag_q, tag_d;
  logic [15:0]           hold_q, hold_d;
  logic                  we_q, we_d;
  logic [RAM_ADDR_W-1:0] ra_q, ra_d;
  logic [31:0]           wd_q, wd_d;

  logic [ADDR_W-1:0] origin;
  logic [ADDR_W-1:0] in_step;
  logic [ADDR_W-1:0] out_step;
  logic [TW-1:0]     cap_tag;
  logic              issue;

  always_comb begin
    origin = Base_address
           + ADDR_W'((32'(Block_row) << DW) * 32'(Row_stride))
           + ADDR_W'(32'(Block_col) << DW);
    in_step  = tr_q ? ADDR_W'(stride_q) : ADDR_W'(1);
    out_step = tr_q ? ADDR_W'(1) : ADDR_W'(stride_q);
  end

  // inner index walks the address by in_step; outer base by out_step
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    stride_d = stride_q;
    tr_d     = tr_q;
    in_d     = in_q;
    out_d    = out_q;
    drain_d  = drain_q;
    issue    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_ISSUE;
          addr_d   = origin;
          base_d   = origin;
          stride_d = Row_stride;
          tr_d     = Transpose;
          in_d     = '0;
          out_d    = '0;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (&in_q) begin
          in_d   = '0;
          out_d  = out_q + DW'(1);
          base_d = base_q + out_step;
          addr_d = base_q + out_step;
          if (&out_q) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else begin
          in_d   = in_q + DW'(1);
          addr_d = addr_q + in_step;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(L)) state_d = S_DONE;
        else drain_d = drain_q + 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // tag pipeline tracks which sample is arriving on SRAM_read_data
  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = issue;
    tag_d[0] = {out_q, in_q};
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    cap_tag = tag_q[L-1];
    hold_d  = hold_q;
    we_d    = 1'b0;
    ra_d    = ra_q;
    wd_d    = wd_q;
    if (vld_q[L-1]) begin
      if (cap_tag[0]) begin
        we_d = 1'b1;
        ra_d = RAM_ADDR_W'(cap_tag[TW-1:1]);
        wd_d = {hold_q, SRAM_read_data};
      end else begin
        hold_d = SRAM_read_data;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      tr_q     <= 1'b0;
      in_q     <= '0;
      out_q    <= '0;
      drain_q  <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
      hold_q   <= '0;
      we_q     <= 1'b0;
      ra_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      tr_q     <= tr_d;
      in_q     <= in_d;
      out_q    <= out_d;
      drain_q  <= drain_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      ra_q     <= ra_d;
      wd_q     <= wd_d;
    end
  end

  assign SRAM_address    = addr_q;
  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = '0;
  assign RAM_address     = ra_q;
  assign RAM_write_data  = wd_q;
  assign RAM_we          = we_q;
  assign Busy            = (state_q != S_IDLE);
  assign Finish          = (state_q == S_DONE);

endmodule

// File: tb/tb_idct_block_fetcher.sv
// Directed bench for idct_block_fetcher: 8x8/L=2 instance (a)
// and 4x4/L=3 instance (b) sharing clock, reset and block inputs.
module tb_idct_block_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, tr = 1'b0;
  logic [17:0] base = '0;
  logic [9:0]  stride = '0;
  logic [5:0]  brow = '0, bcol = '0;
  logic [15:0] rd_a, rd_b;

  logic [17:0] sa_a, sa_b;
  logic        wen_a, wen_b;
  logic [15:0] swd_a, swd_b;
  logic [6:0]  ra_a, ra_b;
  logic [31:0] rwd_a, rwd_b;
  logic        rwe_a, rwe_b, busy_a, busy_b, fin_a, fin_b;

  idct_block_fetcher u_a (
    .Clock(clk), .Resetn(rst_n), .Start(start_a), .Transpose(tr),
    .Base_address(base), .Row_stride(stride),
    .Block_row(brow), .Block_col(bcol), .SRAM_read_data(rd_a),
    .SRAM_address(sa_a), .SRAM_we_n(wen_a), .SRAM_write_data(swd_a),
    .RAM_address(ra_a), .RAM_write_data(rwd_a), .RAM_we(rwe_a),
    .Busy(busy_a), .Finish(fin_a)
  );

  idct_block_fetcher #(.BLOCK_DIM(4), .SRAM_LATENCY(3)) u_b (
    .Clock(clk), .Resetn(rst_n), .Start(start_b), .Transpose(tr),
    .Base_address(base), .Row_stride(stride),
    .Block_row(brow), .Block_col(bcol), .SRAM_read_data(rd_b),
    .SRAM_address(sa_b), .SRAM_we_n(wen_b), .SRAM_write_data(swd_b),
    .RAM_address(ra_b), .RAM_write_data(rwd_b), .RAM_we(rwe_b),
    .Busy(busy_b), .Finish(fin_b)
  );

  // SRAM models: data = address low bits, after the configured latency
  logic [17:0] pa0 = '0, pa1 = '0, pb0 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) begin
    pa0 <= sa_a; pa1 <= pa0;
    pb0 <= sa_b; pb1 <= pb0; pb2 <= pb1;
  end
  assign rd_a = pa1[15:0];
  assign rd_b = (pb2 == 18'h3FFF0) ? 16'h8000 :
                (pb2 == 18'h3FFF1) ? 16'h7FFF : pb2[15:0];

  int cyc = 0, c0a = 0, c0b = 0;
  always @(posedge clk) cyc++;

  int pass_n = 0, total_n = 0;

  logic [31:0] mem_a [0:127];
  logic [31:0] mem_b [0:127];
  logic [17:0] alog_a [0:299];
  logic [17:0] alog_b [0:299];
  logic        blog_a [0:299];
  int nwr_a, nfin_a, fc_a, fw_a, lw_a, rel_a;
  int nwr_b, nfin_b, fc_b, fw_b, rel_b;

  always @(negedge clk) begin
    rel_a = cyc - c0a;
    if (rwe_a) begin
      if (nwr_a == 0) fw_a = rel_a;
      lw_a = rel_a;
      mem_a[ra_a] = rwd_a;
      nwr_a++;
    end
    if (fin_a) begin nfin_a++; fc_a = rel_a; end
    if (rel_a >= 0 && rel_a < 300) begin
      alog_a[rel_a] = sa_a;
      blog_a[rel_a] = busy_a;
    end
    rel_b = cyc - c0b;
    if (rwe_b) begin
      if (nwr_b == 0) fw_b = rel_b;
      mem_b[ra_b] = rwd_b;
      nwr_b++;
    end
    if (fin_b) begin nfin_b++; fc_b = rel_b; end
    if (rel_b >= 0 && rel_b < 300) alog_b[rel_b] = sa_b;
  end

  task automatic clear_a();
    nwr_a = 0; nfin_a = 0; fc_a = -1; fw_a = -1; lw_a = -1;
    for (int i = 0; i < 128; i++) mem_a[i] = 'x;
    for (int i = 0; i < 300; i++) begin alog_a[i] = 'x; blog_a[i] = 1'bx; end
  endtask

  task automatic clear_b();
    nwr_b = 0; nfin_b = 0; fc_b = -1; fw_b = -1;
    for (int i = 0; i < 128; i++) mem_b[i] = 'x;
    for (int i = 0; i < 300; i++) alog_b[i] = 'x;
  endtask

  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1; c0a = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic poke_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic at_a(input int k);
    while (cyc - c0a < k) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_n++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy_a); else pass_n++;
    total_n++; if (fin_a !== 1'b0) $display("FAIL rst_finish got %0b want 0", fin_a); else pass_n++;
    total_n++; if (rwe_a !== 1'b0) $display("FAIL rst_we got %0b want 0", rwe_a); else pass_n++;
    total_n++; if (sa_a !== 18'h0) $display("FAIL rst_saddr got %0h want 0", sa_a); else pass_n++;
    total_n++; if (ra_a !== 7'h0) $display("FAIL rst_raddr got %0h want 0", ra_a); else pass_n++;
    total_n++; if (rwd_a !== 32'h0) $display("FAIL rst_rdata got %0h want 0", rwd_a); else pass_n++;
    total_n++; if (wen_a !== 1'b1) $display("FAIL rst_we_n got %0b want 1", wen_a); else pass_n++;
    total_n++; if (swd_a !== 16'h0) $display("FAIL rst_swdata got %0h want 0", swd_a); else pass_n++;
    total_n++; if (busy_b !== 1'b0) $display("FAIL rst_busy_b got %0b want 0", busy_b); else pass_n++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_row_major();
    base = 18'h0; stride = 10'd320; brow = 6'd0; bcol = 6'd0; tr = 1'b0;
    clear_a();
    pulse_a();
    at_a(72);
    total_n++; if (fc_a !== 68) $display("FAIL row_finish_cyc got %0d want 68", fc_a); else pass_n++;
    total_n++; if (nfin_a !== 1) $display("FAIL row_finish_cnt got %0d want 1", nfin_a); else pass_n++;
    total_n++; if (nwr_a !== 32) $display("FAIL row_writes got %0d want 32", nwr_a); else pass_n++;
    total_n++; if (fw_a !== 5) $display("FAIL row_first_wr got %0d want 5", fw_a); else pass_n++;
    total_n++; if (lw_a !== 67) $display("FAIL row_last_wr got %0d want 67", lw_a); else pass_n++;
    total_n++; if (mem_a[0] !== 32'h0000_0001) $display("FAIL row_ram0 got %0h want 00000001", mem_a[0]); else pass_n++;
    total_n++; if (mem_a[4] !== 32'h0140_0141) $display("FAIL row_ram4 got %0h want 01400141", mem_a[4]); else pass_n++;
    total_n++; if (mem_a[31] !== 32'h08C6_08C7) $display("FAIL row_ram31 got %0h want 08c608c7", mem_a[31]); else pass_n++;
    total_n++; if (alog_a[1] !== 18'd0) $display("FAIL row_addr1 got %0h want 0", alog_a[1]); else pass_n++;
    total_n++; if (alog_a[2] !== 18'd1) $display("FAIL row_addr2 got %0h want 1", alog_a[2]); else pass_n++;
    total_n++; if (alog_a[64] !== 18'd2247) $display("FAIL row_addr64 got %0d want 2247", alog_a[64]); else pass_n++;
    total_n++; if (blog_a[0] !== 1'b0) $display("FAIL row_busy0 got %0b want 0", blog_a[0]); else pass_n++;
    total_n++; if (blog_a[1] !== 1'b1) $display("FAIL row_busy1 got %0b want 1", blog_a[1]); else pass_n++;
    total_n++; if (blog_a[68] !== 1'b1) $display("FAIL row_busy68 got %0b want 1", blog_a[68]); else pass_n++;
    total_n++; if (blog_a[69] !== 1'b0) $display("FAIL row_busy69 got %0b want 0", blog_a[69]); else pass_n++;
  endtask

  task automatic test_transpose();
    base = 18'h0; stride = 10'd320; brow = 6'd0; bcol = 6'd0; tr = 1'b1;
    clear_a();
    pulse_a();
    at_a(72);
    tr = 1'b0;
    total_n++; if (fc_a !== 68) $display("FAIL tr_finish_cyc got %0d want 68", fc_a); else pass_n++;
    total_n++; if (nwr_a !== 32) $display("FAIL tr_writes got %0d want 32", nwr_a); else pass_n++;
    total_n++; if (alog_a[2] !== 18'd320) $display("FAIL tr_addr2 got %0d want 320", alog_a[2]); else pass_n++;
    total_n++; if (mem_a[0] !== 32'h0000_0140) $display("FAIL tr_ram0 got %0h want 00000140", mem_a[0]); else pass_n++;
    total_n++; if (mem_a[4] !== 32'h0001_0141) $display("FAIL tr_ram4 got %0h want 00010141", mem_a[4]); else pass_n++;
    total_n++; if (mem_a[31] !== 32'h0787_08C7) $display("FAIL tr_ram31 got %0h want 078708c7", mem_a[31]); else pass_n++;
  endtask

  task automatic test_origin();
    base = 18'h00100; stride = 10'd320; brow = 6'd2; bcol = 6'd39; tr = 1'b0;
    clear_a();
    pulse_a();
    at_a(72);
    total_n++; if (alog_a[1] !== 18'h01638) $display("FAIL org_first got %0h want 1638", alog_a[1]); else pass_n++;
    total_n++; if (alog_a[9] !== 18'h01778) $display("FAIL org_row1 got %0h want 1778", alog_a[9]); else pass_n++;
    total_n++; if (alog_a[64] !== 18'h01EFF) $display("FAIL org_last got %0h want 1eff", alog_a[64]); else pass_n++;
    total_n++; if (mem_a[0] !== 32'h1638_1639) $display("FAIL org_ram0 got %0h want 16381639", mem_a[0]); else pass_n++;
  endtask

  task automatic test_back_to_back();
    base = 18'h0; stride = 10'd320; brow = 6'd0; bcol = 6'd0; tr = 1'b0;
    clear_a();
    pulse_a();
    at_a(10); poke_a();
    at_a(40); poke_a();
    at_a(69);
    total_n++; if (nfin_a !== 1) $display("FAIL b2b_fin_first got %0d want 1", nfin_a); else pass_n++;
    total_n++; if (fc_a !== 68) $display("FAIL b2b_fin_cyc1 got %0d want 68", fc_a); else pass_n++;
    poke_a();
    at_a(141);
    total_n++; if (nfin_a !== 2) $display("FAIL b2b_fin_cnt got %0d want 2", nfin_a); else pass_n++;
    total_n++; if (fc_a !== 137) $display("FAIL b2b_fin_cyc2 got %0d want 137", fc_a); else pass_n++;
    total_n++; if (nwr_a !== 64) $display("FAIL b2b_writes got %0d want 64", nwr_a); else pass_n++;
  endtask

  task automatic test_abort();
    base = 18'h0; stride = 10'd320; brow = 6'd0; bcol = 6'd0; tr = 1'b0;
    clear_a();
    pulse_a();
    at_a(30);
    rst_n = 1'b0;
    @(negedge clk);
    total_n++; if (busy_a !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy_a); else pass_n++;
    total_n++; if (rwe_a !== 1'b0) $display("FAIL abort_we got %0b want 0", rwe_a); else pass_n++;
    total_n++; if (sa_a !== 18'h0) $display("FAIL abort_saddr got %0h want 0", sa_a); else pass_n++;
    total_n++; if (rwd_a !== 32'h0) $display("FAIL abort_rdata got %0h want 0", rwd_a); else pass_n++;
    total_n++; if (ra_a !== 7'h0) $display("FAIL abort_raddr got %0h want 0", ra_a); else pass_n++;
    rst_n = 1'b1;
    nwr_a = 0;
    repeat (80) @(negedge clk);
    total_n++; if (nwr_a !== 0) $display("FAIL abort_late_wr got %0d want 0", nwr_a); else pass_n++;
    total_n++; if (nfin_a !== 0) $display("FAIL abort_finish got %0d want 0", nfin_a); else pass_n++;
    clear_a();
    pulse_a();
    at_a(72);
    total_n++; if (fc_a !== 68) $display("FAIL abort_refetch_fin got %0d want 68", fc_a); else pass_n++;
    total_n++; if (nwr_a !== 32) $display("FAIL abort_refetch_wr got %0d want 32", nwr_a); else pass_n++;
    total_n++; if (mem_a[31] !== 32'h08C6_08C7) $display("FAIL abort_ram31 got %0h want 08c608c7", mem_a[31]); else pass_n++;
  endtask

  task automatic test_small_wrap();
    base = 18'h3FFF0; stride = 10'd8; brow = 6'd0; bcol = 6'd0; tr = 1'b0;
    clear_b();
    @(negedge clk);
    start_b = 1'b1; c0b = cyc;
    @(negedge clk);
    start_b = 1'b0;
    repeat (25) @(negedge clk);
    total_n++; if (fc_b !== 21) $display("FAIL small_fin_cyc got %0d want 21", fc_b); else pass_n++;
    total_n++; if (nfin_b !== 1) $display("FAIL small_fin_cnt got %0d want 1", nfin_b); else pass_n++;
    total_n++; if (nwr_b !== 8) $display("FAIL small_writes got %0d want 8", nwr_b); else pass_n++;
    total_n++; if (fw_b !== 6) $display("FAIL small_first_wr got %0d want 6", fw_b); else pass_n++;
    total_n++; if (mem_b[0] !== 32'h8000_7FFF) $display("FAIL small_ram0 got %0h want 80007fff", mem_b[0]); else pass_n++;
    total_n++; if (mem_b[1] !== 32'hFFF2_FFF3) $display("FAIL small_ram1 got %0h want fff2fff3", mem_b[1]); else pass_n++;
    total_n++; if (mem_b[4] !== 32'h0000_0001) $display("FAIL small_ram4 got %0h want 00000001", mem_b[4]); else pass_n++;
    total_n++; if (mem_b[6] !== 32'h0008_0009) $display("FAIL small_ram6 got %0h want 00080009", mem_b[6]); else pass_n++;
    total_n++; if (alog_b[1] !== 18'h3FFF0) $display("FAIL small_addr1 got %0h want 3fff0", alog_b[1]); else pass_n++;
    total_n++; if (alog_b[9] !== 18'h00000) $display("FAIL small_wrap got %0h want 0", alog_b[9]); else pass_n++;
    total_n++; if (alog_b[16] !== 18'h0000B) $display("FAIL small_addr16 got %0h want b", alog_b[16]); else pass_n++;
  endtask

  initial begin
    clear_a();
    clear_b();
    test_reset();
    test_row_major();
    test_transpose();
    test_origin();
    test_back_to_back();
    test_abort();
    test_small_wrap();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
